// File: rtl/duck_round_controller.sv
// duck_round_controller
// ---------------------------------------------------------------------------
// Game sequencer for the duck-hunt game. Spawns each duck, runs its flight
// timer, counts shots, registers hits into a saturating score, advances
// rounds and declares game over. Everything is counted on clk.
//
// Optional feature macro: DUCK_ROUND_BONUS_EN
//   defined   -> a round in which every duck was hit adds 10 to score
//                (saturating at 127) in the same cycle as the round advance.
//   undefined -> score counts hits only.
//
// Ports
//   clk             system clock
//   rst             synchronous, active-low reset
//   frame_tick      one-clk pulse per video frame
//   mouse_left      left button level (clk-synchronous)
//   mouse_right     right button level, start/restart
//   cursor_on_duck  cursor currently inside the duck area
//   duck_spawn      one-cycle pulse, new duck launched
//   duck_active     high while in FLY
//   duck_shot       one-cycle pulse on a hit
//   duck_escaped    one-cycle pulse on an escape
//   score           total hits, saturating at 127
//   shots_left      remaining shots for the current duck
//   duck_num        index of the current duck in the round
//   round           current round (1..15, 0 after reset)
//   game_over       high in GAME_OVER
//   state           current FSM state, for debug
//
// All outputs come straight from flops. The pulse outputs carry no
// handshake: each is high for exactly one clk and the consumer must
// sample it on that cycle.
// ---------------------------------------------------------------------------
module duck_round_controller #(
  parameter int FLIGHT_FRAMES   = 240,
  parameter int ANIM_FRAMES     = 60,
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int DUCKS_PER_ROUND = 10,
  parameter int PASS_HITS       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       mouse_left,
  input  logic       mouse_right,
  input  logic       cursor_on_duck,
  output logic       duck_spawn,
  output logic       duck_active,
  output logic       duck_shot,
  output logic       duck_escaped,
  output logic [6:0] score,
  output logic [1:0] shots_left,
  output logic [3:0] duck_num,
  output logic [3:0] round,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SPAWN     = 3'd1,
    ST_FLY       = 3'd2,
    ST_HIT       = 3'd3,
    ST_ESCAPE    = 3'd4,
    ST_ROUND_END = 3'd5,
    ST_GAME_OVER = 3'd6
  } state_t;

  localparam logic [9:0] FLIGHT_L    = 10'(FLIGHT_FRAMES);
  localparam logic [9:0] ANIM_L      = 10'(ANIM_FRAMES);
  localparam logic [1:0] SHOTS_L     = 2'(SHOTS_PER_DUCK);
  localparam logic [3:0] LAST_DUCK_L = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [3:0] PASS_L      = 4'(PASS_HITS);
`ifdef DUCK_ROUND_BONUS_EN
  localparam logic [3:0] DUCKS_L     = 4'(DUCKS_PER_ROUND);
`endif

  state_t     state_q, state_d;
  logic [9:0] timer_q, timer_d;
  logic [6:0] score_q, score_d;
  logic [1:0] shots_q, shots_d;
  logic [3:0] duck_num_q, duck_num_d;
  logic [3:0] round_q, round_d;
  logic [3:0] hits_q, hits_d;
  logic       left_q, left_d, left_prev_q, left_prev_d;
  logic       right_q, right_d, right_prev_q, right_prev_d;
  logic       duck_spawn_q, duck_spawn_d;
  logic       duck_active_q, duck_active_d;
  logic       duck_shot_q, duck_shot_d;
  logic       duck_escaped_q, duck_escaped_d;
  logic       game_over_q, game_over_d;

  logic       left_rise, right_rise;
  logic       shot_fire, timer_expire;
  logic [6:0] score_inc;
`ifdef DUCK_ROUND_BONUS_EN
  logic [7:0] bonus_sum;
  logic [6:0] score_bonus;
`endif

  // Edges come from the registered copies, so a press costs one cycle of
  // latency before the FSM reacts to it.
  assign left_rise    = left_q & ~left_prev_q;
  assign right_rise   = right_q & ~right_prev_q;
  assign shot_fire    = left_rise && (shots_q != 2'd0);
  // The timer is loaded on the entry transition, so a tick that coincides
  // with the load never reaches the decrement path.
  assign timer_expire = frame_tick && (timer_q <= 10'd1);
  assign score_inc    = (score_q == 7'd127) ? 7'd127 : score_q + 7'd1;
`ifdef DUCK_ROUND_BONUS_EN
  assign bonus_sum    = {1'b0, score_q} + 8'd10;
  assign score_bonus  = bonus_sum[7] ? 7'd127 : bonus_sum[6:0];
`endif

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    score_d      = score_q;
    shots_d      = shots_q;
    duck_num_d   = duck_num_q;
    round_d      = round_q;
    hits_d       = hits_q;
    left_d       = mouse_left;
    left_prev_d  = left_q;
    right_d      = mouse_right;
    right_prev_d = right_q;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (right_rise) begin
          score_d    = 7'd0;
          hits_d     = 4'd0;
          round_d    = 4'd1;
          duck_num_d = 4'd0;
          state_d    = ST_SPAWN;
        end
      end
      ST_SPAWN: begin
        timer_d = FLIGHT_L;
        state_d = ST_FLY;
      end
      ST_FLY: begin
        if (frame_tick && (timer_q != 10'd0)) timer_d = timer_q - 10'd1;
        // A shot is resolved before the timer: a hit wins over expiry.
        if (shot_fire) begin
          shots_d = shots_q - 2'd1;
          if (cursor_on_duck) begin
            state_d = ST_HIT;
            score_d = score_inc;
            hits_d  = hits_q + 4'd1;
            timer_d = ANIM_L;
          end else if ((shots_q == 2'd1) || timer_expire) begin
            state_d = ST_ESCAPE;
            timer_d = ANIM_L;
          end
        end else if (timer_expire) begin
          state_d = ST_ESCAPE;
          timer_d = ANIM_L;
        end
      end
      ST_HIT, ST_ESCAPE: begin
        if (frame_tick) begin
          if (timer_q <= 10'd1) begin
            timer_d = 10'd0;
            if (duck_num_q == LAST_DUCK_L) begin
              state_d = ST_ROUND_END;
            end else begin
              duck_num_d = duck_num_q + 4'd1;
              state_d    = ST_SPAWN;
            end
          end else begin
            timer_d = timer_q - 10'd1;
          end
        end
      end
      ST_ROUND_END: begin
        if (hits_q >= PASS_L) begin
          round_d    = (round_q == 4'd15) ? 4'd15 : round_q + 4'd1;
          duck_num_d = 4'd0;
          hits_d     = 4'd0;
          state_d    = ST_SPAWN;
`ifdef DUCK_ROUND_BONUS_EN
          if (hits_q == DUCKS_L) score_d = score_bonus;
`endif
        end else begin
          state_d = ST_GAME_OVER;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // SPAWN is always a one-cycle state, so entering it is the same as
    // state_d being SPAWN.
    if (state_d == ST_SPAWN) shots_d = SHOTS_L;

    duck_spawn_d   = (state_d == ST_SPAWN);
    duck_active_d  = (state_d == ST_FLY);
    duck_shot_d    = (state_q == ST_FLY) && (state_d == ST_HIT);
    duck_escaped_d = (state_q == ST_FLY) && (state_d == ST_ESCAPE);
    game_over_d    = (state_d == ST_GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      timer_q        <= 10'd0;
      score_q        <= 7'd0;
      shots_q        <= 2'd0;
      duck_num_q     <= 4'd0;
      round_q        <= 4'd0;
      hits_q         <= 4'd0;
      left_q         <= 1'b0;
      left_prev_q    <= 1'b0;
      right_q        <= 1'b0;
      right_prev_q   <= 1'b0;
      duck_spawn_q   <= 1'b0;
      duck_active_q  <= 1'b0;
      duck_shot_q    <= 1'b0;
      duck_escaped_q <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      score_q        <= score_d;
      shots_q        <= shots_d;
      duck_num_q     <= duck_num_d;
      round_q        <= round_d;
      hits_q         <= hits_d;
      left_q         <= left_d;
      left_prev_q    <= left_prev_d;
      right_q        <= right_d;
      right_prev_q   <= right_prev_d;
      duck_spawn_q   <= duck_spawn_d;
      duck_active_q  <= duck_active_d;
      duck_shot_q    <= duck_shot_d;
      duck_escaped_q <= duck_escaped_d;
      game_over_q    <= game_over_d;
    end
  end

  assign duck_spawn   = duck_spawn_q;
  assign duck_active  = duck_active_q;
  assign duck_shot    = duck_shot_q;
  assign duck_escaped = duck_escaped_q;
  assign score        = score_q;
  assign shots_left   = shots_q;
  assign duck_num     = duck_num_q;
  assign round        = round_q;
  assign game_over    = game_over_q;
  assign state        = state_q;

endmodule

// File: tb/tb_duck_round_controller.sv
// Testbench for duck_round_controller (default parameters). A small game
// model (score, round, duck index, round hits) predicts every checked value.
module tb_duck_round_controller;

  localparam int FLIGHT = 240;
  localparam int ANIM   = 60;
  localparam int DUCKS  = 10;
  localparam int PASS   = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, frame_tick, mouse_left, mouse_right, cursor_on_duck;
  logic       duck_spawn, duck_active, duck_shot, duck_escaped, game_over;
  logic [6:0] score;
  logic [1:0] shots_left;
  logic [3:0] duck_num, round;
  logic [2:0] state;

  duck_round_controller dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .mouse_left(mouse_left),
    .mouse_right(mouse_right), .cursor_on_duck(cursor_on_duck),
    .duck_spawn(duck_spawn), .duck_active(duck_active), .duck_shot(duck_shot),
    .duck_escaped(duck_escaped), .score(score), .shots_left(shots_left),
    .duck_num(duck_num), .round(round), .game_over(game_over), .state(state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- game model ----------------
  int m_score, m_round, m_duck, m_hits;
  bit m_over;

  task automatic model_new_game();
    m_score = 0; m_round = 1; m_duck = 0; m_hits = 0; m_over = 0;
  endtask

  task automatic model_hit();
    m_score = (m_score + 1 > 127) ? 127 : m_score + 1;
    m_hits++;
  endtask

  task automatic model_round_end();
    if (m_hits >= PASS) begin
`ifdef DUCK_ROUND_BONUS_EN
      if (m_hits == DUCKS) m_score = (m_score + 10 > 127) ? 127 : m_score + 10;
`endif
      m_round = (m_round + 1 > 15) ? 15 : m_round + 1;
      m_duck = 0;
      m_hits = 0;
    end else begin
      m_over = 1;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
    end
    frame_tick = 1'b0;
  endtask

  // Leaves the bench two edges after the press: the shot result is visible.
  task automatic click(input bit on_duck);
    cursor_on_duck = on_duck;
    mouse_left = 1'b1;
    step();
    mouse_left = 1'b0;
    step();
  endtask

  task automatic press_start();
    mouse_right = 1'b1;
    step();
    mouse_right = 1'b0;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; frame_tick = 0; mouse_left = 0; mouse_right = 0; cursor_on_duck = 0;
    repeat (3) step();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_cmp++; if (score !== 7'd0) begin n_bad++; $display("FAIL reset_score: got %0d expected 0", score); end
    n_cmp++; if (shots_left !== 2'd0) begin n_bad++; $display("FAIL reset_shots: got %0d expected 0", shots_left); end
    n_cmp++; if (round !== 4'd0) begin n_bad++; $display("FAIL reset_round: got %0d expected 0", round); end
    n_cmp++; if (duck_num !== 4'd0) begin n_bad++; $display("FAIL reset_duck_num: got %0d expected 0", duck_num); end
    n_cmp++; if ({duck_spawn, duck_active, duck_shot, duck_escaped, game_over} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 00000",
                        {duck_spawn, duck_active, duck_shot, duck_escaped, game_over}); end
    rst = 1'b1;
    step();
    click(1'b1);
    step();
    n_cmp++; if (state !== 3'd0 || shots_left !== 2'd0 || duck_shot !== 1'b0) begin
      n_bad++; $display("FAIL idle_click_ignored: got state %0d shots %0d expected 0 0", state, shots_left); end
  endtask

  task automatic test_start();
    mouse_right = 1'b1;
    step();
    n_cmp++; if (state !== 3'd0 || duck_spawn !== 1'b0) begin
      n_bad++; $display("FAIL start_latency: got state %0d spawn %b expected 0 0", state, duck_spawn); end
    mouse_right = 1'b0;
    step();
    model_new_game();
    n_cmp++; if (duck_spawn !== 1'b1 || state !== 3'd1) begin
      n_bad++; $display("FAIL start_spawn: got spawn %b state %0d expected 1 1", duck_spawn, state); end
    n_cmp++; if (shots_left !== 2'd3) begin n_bad++; $display("FAIL start_shots: got %0d expected 3", shots_left); end
    n_cmp++; if (round !== 4'(m_round) || duck_num !== 4'(m_duck)) begin
      n_bad++; $display("FAIL start_round: got round %0d duck %0d expected %0d %0d", round, duck_num, m_round, m_duck); end
    step();
    n_cmp++; if (duck_active !== 1'b1 || duck_spawn !== 1'b0 || state !== 3'd2) begin
      n_bad++; $display("FAIL start_fly: got active %b spawn %b state %0d expected 1 0 2", duck_active, duck_spawn, state); end
  endtask

  task automatic test_hit();
    click(1'b1);
    model_hit();
    n_cmp++; if (duck_shot !== 1'b1 || state !== 3'd3) begin
      n_bad++; $display("FAIL hit_pulse: got shot %b state %0d expected 1 3", duck_shot, state); end
    n_cmp++; if (score !== 7'(m_score)) begin n_bad++; $display("FAIL hit_score: got %0d expected %0d", score, m_score); end
    n_cmp++; if (shots_left !== 2'd2 || duck_active !== 1'b0) begin
      n_bad++; $display("FAIL hit_shots: got shots %0d active %b expected 2 0", shots_left, duck_active); end
    step();
    n_cmp++; if (duck_shot !== 1'b0) begin n_bad++; $display("FAIL hit_one_cycle: got %b expected 0", duck_shot); end
    click(1'b1);
    n_cmp++; if (score !== 7'(m_score) || shots_left !== 2'd2) begin
      n_bad++; $display("FAIL anim_click_ignored: got score %0d shots %0d expected %0d 2", score, shots_left, m_score); end
    ticks(ANIM - 1);
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL anim_len_early: got state %0d expected 3", state); end
    ticks(1);
    m_duck++;
    n_cmp++; if (duck_spawn !== 1'b1 || duck_num !== 4'(m_duck) || shots_left !== 2'd3) begin
      n_bad++; $display("FAIL anim_next_spawn: got spawn %b duck %0d shots %0d expected 1 %0d 3",
                        duck_spawn, duck_num, shots_left, m_duck); end
  endtask

  task automatic test_miss_escape();
    step();
    click(1'b0);
    n_cmp++; if (shots_left !== 2'd2 || state !== 3'd2) begin
      n_bad++; $display("FAIL miss1: got shots %0d state %0d expected 2 2", shots_left, state); end
    click(1'b0);
    n_cmp++; if (shots_left !== 2'd1 || state !== 3'd2) begin
      n_bad++; $display("FAIL miss2: got shots %0d state %0d expected 1 2", shots_left, state); end
    click(1'b0);
    n_cmp++; if (duck_escaped !== 1'b1 || shots_left !== 2'd0 || state !== 3'd4) begin
      n_bad++; $display("FAIL miss3_escape: got esc %b shots %0d state %0d expected 1 0 4", duck_escaped, shots_left, state); end
    n_cmp++; if (score !== 7'(m_score) || duck_shot !== 1'b0) begin
      n_bad++; $display("FAIL miss_score: got %0d expected %0d", score, m_score); end
    ticks(ANIM);
    m_duck++;
    n_cmp++; if (duck_spawn !== 1'b1 || duck_num !== 4'(m_duck)) begin
      n_bad++; $display("FAIL escape_next_spawn: got spawn %b duck %0d expected 1 %0d", duck_spawn, duck_num, m_duck); end
  endtask

  task automatic test_timeout();
    ticks(1); // lands on the timer-load cycle, must not count
    ticks(FLIGHT - 1);
    n_cmp++; if (state !== 3'd2 || duck_escaped !== 1'b0) begin
      n_bad++; $display("FAIL timeout_early: got state %0d esc %b expected 2 0", state, duck_escaped); end
    ticks(1);
    n_cmp++; if (duck_escaped !== 1'b1 || state !== 3'd4 || shots_left !== 2'd3) begin
      n_bad++; $display("FAIL timeout_escape: got esc %b state %0d shots %0d expected 1 4 3", duck_escaped, state, shots_left); end
    ticks(ANIM);
    m_duck++;
    n_cmp++; if (duck_spawn !== 1'b1 || duck_num !== 4'(m_duck)) begin
      n_bad++; $display("FAIL timeout_next_spawn: got spawn %b duck %0d expected 1 %0d", duck_spawn, duck_num, m_duck); end
  endtask

  task automatic test_hit_on_expiry();
    step();
    ticks(FLIGHT - 1);
    cursor_on_duck = 1'b1;
    mouse_left = 1'b1;
    step();
    mouse_left = 1'b0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    model_hit();
    n_cmp++; if (duck_shot !== 1'b1 || duck_escaped !== 1'b0 || state !== 3'd3) begin
      n_bad++; $display("FAIL expiry_hit: got shot %b esc %b state %0d expected 1 0 3", duck_shot, duck_escaped, state); end
    n_cmp++; if (score !== 7'(m_score)) begin n_bad++; $display("FAIL expiry_score: got %0d expected %0d", score, m_score); end
    ticks(ANIM);
    m_duck++;
  endtask

  task automatic test_random_round();
    for (int d = m_duck; d < DUCKS; d++) begin
      int misses;
      step();
      misses = $urandom_range(0, 3);
      for (int k = 0; k < misses; k++) begin
        ticks($urandom_range(0, 15));
        click(1'b0);
      end
      if (misses < 3) begin
        ticks($urandom_range(0, 15));
        click(1'b1);
        model_hit();
        n_cmp++; if (duck_shot !== 1'b1 || score !== 7'(m_score)) begin
          n_bad++; $display("FAIL rand_hit d%0d: got shot %b score %0d expected 1 %0d", d, duck_shot, score, m_score); end
      end else begin
        n_cmp++; if (duck_escaped !== 1'b1 || score !== 7'(m_score)) begin
          n_bad++; $display("FAIL rand_escape d%0d: got esc %b score %0d expected 1 %0d", d, duck_escaped, score, m_score); end
      end
      ticks(ANIM);
      if (d < DUCKS - 1) begin
        m_duck++;
        n_cmp++; if (state !== 3'd1 || duck_num !== 4'(m_duck)) begin
          n_bad++; $display("FAIL rand_spawn d%0d: got state %0d duck %0d expected 1 %0d", d, state, duck_num, m_duck); end
      end else begin
        n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL rand_round_end: got state %0d expected 5", state); end
      end
    end
    step();
    model_round_end();
    n_cmp++; if (state !== (m_over ? 3'd6 : 3'd1) || game_over !== m_over) begin
      n_bad++; $display("FAIL rand_outcome: got state %0d over %b expected over %b", state, game_over, m_over); end
    n_cmp++; if (round !== 4'(m_round) || score !== 7'(m_score)) begin
      n_bad++; $display("FAIL rand_round_score: got round %0d score %0d expected %0d %0d", round, score, m_round, m_score); end
  endtask

  task automatic test_reset_mid_fly();
    if (state == 3'd6) press_start();
    step();
    click(1'b0);
    ticks(5);
    rst = 1'b0;
    step();
    n_cmp++; if (state !== 3'd0 || score !== 7'd0 || shots_left !== 2'd0 || round !== 4'd0 || duck_num !== 4'd0) begin
      n_bad++; $display("FAIL midfly_reset: got state %0d score %0d shots %0d round %0d duck %0d expected all 0",
                        state, score, shots_left, round, duck_num); end
    n_cmp++; if ({duck_spawn, duck_active, duck_shot, duck_escaped, game_over} !== 5'b0) begin
      n_bad++; $display("FAIL midfly_reset_flags: got %b expected 00000",
                        {duck_spawn, duck_active, duck_shot, duck_escaped, game_over}); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_game_over();
    press_start();
    model_new_game();
    for (int d = 0; d < DUCKS; d++) begin
      step();
      if (d == 0) begin
        press_start();
        n_cmp++; if (state !== 3'd2 || duck_spawn !== 1'b0) begin
          n_bad++; $display("FAIL fly_right_ignored: got state %0d spawn %b expected 2 0", state, duck_spawn); end
      end
      if (d < 5) begin
        click(1'b1);
        model_hit();
      end else begin
        repeat (3) click(1'b0);
      end
      ticks(ANIM);
    end
    step();
    model_round_end();
    n_cmp++; if (state !== 3'd6 || game_over !== 1'b1 || duck_active !== 1'b0) begin
      n_bad++; $display("FAIL game_over: got state %0d over %b expected 6 1 (model over %b)", state, game_over, m_over); end
    n_cmp++; if (score !== 7'(m_score) || round !== 4'(m_round)) begin
      n_bad++; $display("FAIL game_over_score: got score %0d round %0d expected %0d %0d", score, round, m_score, m_round); end
    click(1'b1);
    n_cmp++; if (score !== 7'(m_score) || state !== 3'd6) begin
      n_bad++; $display("FAIL over_click_ignored: got score %0d state %0d expected %0d 6", score, state, m_score); end
    press_start();
    model_new_game();
    n_cmp++; if (score !== 7'd0 || round !== 4'd1 || duck_num !== 4'd0 || duck_spawn !== 1'b1) begin
      n_bad++; $display("FAIL restart: got score %0d round %0d duck %0d spawn %b expected 0 1 0 1",
                        score, round, duck_num, duck_spawn); end
  endtask

  // Perfect rounds until the score and the round number both saturate.
  task automatic test_full_rounds_saturation();
    for (int r = 0; r < 15; r++) begin
      for (int d = 0; d < DUCKS; d++) begin
        step();
        click(1'b1);
        model_hit();
        n_cmp++; if (duck_shot !== 1'b1 || score !== 7'(m_score)) begin
          n_bad++; $display("FAIL sat_hit r%0d d%0d: got shot %b score %0d expected 1 %0d", r, d, duck_shot, score, m_score); end
        ticks(ANIM);
      end
      step();
      model_round_end();
      n_cmp++; if (state !== 3'd1 || round !== 4'(m_round) || duck_num !== 4'd0) begin
        n_bad++; $display("FAIL round_advance r%0d: got state %0d round %0d duck %0d expected 1 %0d 0",
                          r, state, round, duck_num, m_round); end
      n_cmp++; if (score !== 7'(m_score)) begin
        n_bad++; $display("FAIL round_score r%0d: got %0d expected %0d", r, score, m_score); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_start();
    test_hit();
    test_miss_escape();
    test_timeout();
    test_hit_on_expiry();
    test_random_round();
    test_reset_mid_fly();
    test_game_over();
    test_full_rounds_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
